alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers (x0 hardwired zero).
REQ-002 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_inst_valid  in  1  instruction offered.
REQ-005 SHALL have port i_inst  in  32  RV32I instruction word.
REQ-006 SHALL have port o_inst_ready  out  1  instruction accepted this cycle when high with i_inst_valid.
REQ-007 SHALL have ports i_wb_en  in  1, i_wb_rd  in  5, i_wb_data  in  data_t: register writeback.
REQ-008 SHALL have ports o_valid  out  1, i_ready  in  1: issue handshake to the ALU stage.
REQ-009 SHALL have ports o_alu_op  out  alu_t, o_a  out  data_t, o_b  out  data_t, o_rd  out  5: registered ALU operands and destination.
REQ-010 SHALL have port o_illegal  out  1  one-cycle pulse on an accepted undecodable instruction.

Function
REQ-011 SHALL decode OP (0110011), OP-IMM (0010011), LUI (0110111); every other opcode is illegal.
REQ-012 SHALL map funct3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; funct7[5] selects SUB/SRA for OP, SRA only for OP-IMM.
REQ-013 SHALL flag illegal: OP with funct7 not 0000000/0100000 (0100000 only on 000/101); OP-IMM shifts with imm[11:5] not 0000000/0100000.
REQ-014 SHALL sign-extend I-immediate to XLEN; shifts use imm[4:0]; LUI yields op ADD, a=0, b={imm[31:12],12'b0}.
REQ-015 SHALL hold a two-state output FSM: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-016 SHALL assert o_inst_ready when (EMPTY or i_ready) and no hazard; accepted legal instruction -> FULL next cycle (latency 1).
REQ-017 SHALL go FULL->EMPTY when i_ready and no instruction accepted; hold all outputs stable while FULL and !i_ready.
REQ-018 SHALL keep a busy bit per register: set on issue of rd!=0, cleared on i_wb_en for i_wb_rd.
REQ-019 SHALL declare hazard if rs1, rs2 (when used) or rd is busy; x0 never busy.
REQ-020 SHALL, on same-cycle writeback clear and issue set of one register, leave it busy.
REQ-021 SHALL write i_wb_data to register i_wb_rd on i_wb_en; writes to x0 ignored.
REQ-022 SHALL on an accepted illegal instruction pulse o_illegal, not change FSM state or busy bits.

Reset
REQ-023 SHALL on i_rst: FSM EMPTY, o_valid=0, o_illegal=0, all busy bits 0, o_alu_op=ALU_ADD, o_a=o_b=0, o_rd=0, all registers 0.
REQ-024 SHALL on reset mid-operation discard any held issue and pending writebacks immediately.

Configuration
REQ-025 SHALL compile writeback bypass when ALU_ISSUE_BYPASS_EN is defined: a source busy but written this cycle is not a hazard and reads i_wb_data.
REQ-026 SHALL without ALU_ISSUE_BYPASS_EN treat it as a hazard; the instruction issues the following cycle with the stored value.

Structure
REQ-027 SHALL take alu_t and ALU_* from package alu; data_t/XLEN from types/params; opcode constants and reg_idx_t added to package params.
REQ-028 SHALL instantiate sub-module regfile (2 async read, 1 write port, async reset).

Verification
REQ-029 SHALL cover: wb x1=5, x2=3; issue SUB x3,x1,x2 -> next cycle o_valid=1, op ALU_SUB, a=5, b=3, rd=3.
REQ-030 SHALL cover: ADDI x4,x0,-1 -> b=32'hFFFFFFFF; LUI x5,0x12345 -> a=0, b=32'h12345000.
REQ-031 SHALL cover: issue to x3, then ADD x6,x3,x3 -> o_inst_ready=0 until wb x3=9; with BYPASS_EN issues same cycle a=b=9, without one cycle later.
REQ-032 SHALL cover: i_ready=0 for 4 cycles while FULL -> outputs constant, o_inst_ready=0; back-to-back issue at full rate with i_ready=1.
REQ-033 SHALL cover: inst 32'h0000007F and SLLI funct7=0000001 -> o_illegal pulse, o_valid unchanged.
REQ-034 SHALL cover: i_rst asserted while FULL with busy x3 -> o_valid=0 and x3 free in the same cycle, no clock edge needed.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for alu_issue: package params (XLEN, data_t, reg_idx_t, opcodes)
// and package alu (alu_t and the funct3 -> ALU operation mapping).
package params;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
endpackage

package alu;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_t;

    // alt selects SUB on 000 and SRA on 101; ignored elsewhere.
    function automatic alu_t f3_to_op(input logic [2:0] f3, input logic alt);
        alu_t op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two asynchronous read ports, one write port,
// asynchronous reset. x0 reads as zero and ignores writes.
module regfile
    import params::*;
#(
    parameter int NREGS = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  reg_idx_t wa,
    input  data_t    wd,
    input  reg_idx_t ra1,
    input  reg_idx_t ra2,
    output data_t    rd1,
    output data_t    rd2
);

    data_t regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 != '0) ? regs[ra1] : '0;
    assign rd2 = (ra2 != '0) ? regs[ra2] : '0;

endmodule

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI decode and single-entry issue stage with a busy-bit scoreboard.
// Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback data into a waiting source.
module alu_issue
    import params::*;
    import alu::*;
#(
    parameter int NREGS = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_valid,
    input  logic [31:0] i_inst,
    output logic        o_inst_ready,
    input  logic        i_wb_en,
    input  reg_idx_t    i_wb_rd,
    input  data_t       i_wb_data,
    output logic        o_valid,
    input  logic        i_ready,
    output alu_t        o_alu_op,
    output data_t       o_a,
    output data_t       o_b,
    output reg_idx_t    o_rd,
    output logic        o_illegal
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state, state_next;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    reg_idx_t   rd_idx, rs1_idx, rs2_idx;

    assign opcode  = i_inst[6:0];
    assign rd_idx  = i_inst[11:7];
    assign funct3  = i_inst[14:12];
    assign rs1_idx = i_inst[19:15];
    assign rs2_idx = i_inst[24:20];
    assign funct7  = i_inst[31:25];

    logic  legal, uses_rs1, uses_rs2, use_imm, is_lui;
    alu_t  dec_op;
    data_t imm;

    always_comb begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        use_imm  = 1'b0;
        is_lui   = 1'b0;
        dec_op   = ALU_ADD;
        imm      = {{20{i_inst[31]}}, i_inst[31:20]};
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                legal    = (funct7 == 7'b0000000) ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec_op   = f3_to_op(funct3, funct7[5]);
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                use_imm  = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift amounts come from imm[4:0]; imm[11:5] is funct7.
                    legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    imm    = {27'b0, i_inst[24:20]};
                    dec_op = f3_to_op(funct3, funct7[5] && funct3 == 3'b101);
                end else begin
                    legal  = 1'b1;
                    dec_op = f3_to_op(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                legal  = 1'b1;
                is_lui = 1'b1;
                imm    = {i_inst[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    logic [NREGS-1:0] busy, set_mask, clr_mask;
    data_t            rf_a, rf_b, src1, src2;
    logic             busy1, busy2, hazard, accept, issue;

    regfile #(.NREGS(NREGS)) u_regfile (
        .clk (i_clk),
        .rst (i_rst),
        .we  (i_wb_en),
        .wa  (i_wb_rd),
        .wd  (i_wb_data),
        .ra1 (rs1_idx),
        .ra2 (rs2_idx),
        .rd1 (rf_a),
        .rd2 (rf_b)
    );

`ifdef ALU_ISSUE_BYPASS_EN
    logic hit1, hit2;
    assign hit1  = i_wb_en && (i_wb_rd == rs1_idx) && (rs1_idx != '0);
    assign hit2  = i_wb_en && (i_wb_rd == rs2_idx) && (rs2_idx != '0);
    assign busy1 = busy[rs1_idx] && !hit1;
    assign busy2 = busy[rs2_idx] && !hit2;
    assign src1  = hit1 ? i_wb_data : rf_a;
    assign src2  = hit2 ? i_wb_data : rf_b;
`else
    assign busy1 = busy[rs1_idx];
    assign busy2 = busy[rs2_idx];
    assign src1  = rf_a;
    assign src2  = rf_b;
`endif

    // Destination busy still blocks so at most one write per register is in flight.
    assign hazard = (uses_rs1 && busy1) || (uses_rs2 && busy2) || (legal && busy[rd_idx]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        o_inst_ready = (state == EMPTY || i_ready) && !hazard;
        accept       = i_inst_valid && o_inst_ready;
        issue        = accept && legal;
        if (state == EMPTY) begin
            if (issue) state_next = FULL;
        end else begin
            if (i_ready && !issue) state_next = EMPTY;
        end
    end

    assign o_valid = (state == FULL);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue && rd_idx != '0) set_mask[rd_idx] = 1'b1;
        if (i_wb_en)               clr_mask[i_wb_rd] = 1'b1;
    end

    // Set wins over clear so a same-cycle writeback cannot free a freshly issued rd.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy      <= '0;
            o_alu_op  <= ALU_ADD;
            o_a       <= '0;
            o_b       <= '0;
            o_rd      <= '0;
            o_illegal <= 1'b0;
        end else begin
            busy      <= (busy & ~clr_mask) | set_mask;
            o_illegal <= accept && !legal;
            if (issue) begin
                o_alu_op <= dec_op;
                o_a      <= is_lui ? '0 : src1;
                o_b      <= (use_imm || is_lui) ? imm : src2;
                o_rd     <= rd_idx;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue; expectations follow the build's ALU_ISSUE_BYPASS_EN setting.
module tb_alu_issue;
    import params::*;
    import alu::*;

    logic        clk = 1'b0;
    logic        rst, inst_valid, inst_ready, wb_en, valid, ready, illegal;
    logic [31:0] inst;
    reg_idx_t    wb_rd, rd;
    data_t       wb_data, a, b;
    alu_t        alu_op;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    alu_issue #(.NREGS(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_inst_valid (inst_valid),
        .i_inst       (inst),
        .o_inst_ready (inst_ready),
        .i_wb_en      (wb_en),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_alu_op     (alu_op),
        .o_a          (a),
        .o_b          (b),
        .o_rd         (rd),
        .o_illegal    (illegal)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rdi);
        return {f7, rs2, rs1, f3, rdi, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rdi);
        return {imm12, rs1, f3, rdi, 7'b0010011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_back(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_valid = 1'b0; inst = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; ready = 1'b1;
        tick(); tick();
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", valid); end
        vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0d want 0", illegal); end
        vectors++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL reset_op got %0d want %0d", alu_op, ALU_ADD); end
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL reset_a got %h want 0", a); end
        vectors++; if (b !== 32'h0) begin errors++; $display("FAIL reset_b got %h want 0", b); end
        vectors++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd); end
        rst = 1'b0;
        #1;
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", inst_ready); end
    endtask

    task automatic test_sub();
        write_back(5'd1, 32'd5);
        write_back(5'd2, 32'd3);
        inst_valid = 1'b1; inst = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        #1;
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL sub_ready got %0d want 1", inst_ready); end
        tick();
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0d want 1", valid); end
        vectors++; if (alu_op !== ALU_SUB) begin errors++; $display("FAIL sub_op got %0d want %0d", alu_op, ALU_SUB); end
        vectors++; if (a !== 32'd5) begin errors++; $display("FAIL sub_a got %h want 5", a); end
        vectors++; if (b !== 32'd3) begin errors++; $display("FAIL sub_b got %h want 3", b); end
        vectors++; if (rd !== 5'd3) begin errors++; $display("FAIL sub_rd got %0d want 3", rd); end
    endtask

    task automatic test_back_to_back();
        inst = enc_i(12'hFFF, 5'd0, 3'b000, 5'd4);
        tick();
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0d want 1", valid); end
        vectors++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL addi_op got %0d want %0d", alu_op, ALU_ADD); end
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL addi_a got %h want 0", a); end
        vectors++; if (b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_b got %h want ffffffff", b); end
        vectors++; if (rd !== 5'd4) begin errors++; $display("FAIL addi_rd got %0d want 4", rd); end
        inst = {20'h12345, 5'd5, 7'b0110111};
        tick();
        vectors++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL lui_op got %0d want %0d", alu_op, ALU_ADD); end
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL lui_a got %h want 0", a); end
        vectors++; if (b !== 32'h12345000) begin errors++; $display("FAIL lui_b got %h want 12345000", b); end
        vectors++; if (rd !== 5'd5) begin errors++; $display("FAIL lui_rd got %0d want 5", rd); end
        inst = enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd7);
        tick();
        inst_valid = 1'b0;
        vectors++; if (alu_op !== ALU_SRA) begin errors++; $display("FAIL srai_op got %0d want %0d", alu_op, ALU_SRA); end
        vectors++; if (a !== 32'd5) begin errors++; $display("FAIL srai_a got %h want 5", a); end
        vectors++; if (b !== 32'd3) begin errors++; $display("FAIL srai_b got %h want 3", b); end
        vectors++; if (rd !== 5'd7) begin errors++; $display("FAIL srai_rd got %0d want 7", rd); end
        tick();
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0d want 0", valid); end
    endtask

    task automatic test_hazard();
        inst_valid = 1'b1; inst = enc_r(7'b0000000, 5'd3, 5'd3, 3'b000, 5'd6);
        #1;
        vectors++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL haz_ready0 got %0d want 0", inst_ready); end
        tick();
        vectors++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL haz_ready1 got %0d want 0", inst_ready); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL haz_valid got %0d want 0", valid); end
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd9;
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL haz_wb_ready got %0d want 1", inst_ready); end
        tick();
        wb_en = 1'b0; inst_valid = 1'b0;
`else
        vectors++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL haz_wb_ready got %0d want 0", inst_ready); end
        tick();
        wb_en = 1'b0;
        #1;
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL haz_after_ready got %0d want 1", inst_ready); end
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL haz_after_valid got %0d want 0", valid); end
        tick();
        inst_valid = 1'b0;
`endif
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL haz_issue_valid got %0d want 1", valid); end
        vectors++; if (a !== 32'd9) begin errors++; $display("FAIL haz_a got %h want 9", a); end
        vectors++; if (b !== 32'd9) begin errors++; $display("FAIL haz_b got %h want 9", b); end
        vectors++; if (rd !== 5'd6) begin errors++; $display("FAIL haz_rd got %0d want 6", rd); end
        tick();
    endtask

    task automatic test_stall();
        ready = 1'b0;
        inst_valid = 1'b1; inst = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd8);
        tick();
        inst = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %0d want 0", i, inst_ready); end
            vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0d want 1", i, valid); end
            vectors++; if (a !== 32'd5 || b !== 32'd3) begin errors++; $display("FAIL stall_ab[%0d] got %h/%h want 5/3", i, a, b); end
            vectors++; if (rd !== 5'd8 || alu_op !== ALU_ADD) begin errors++; $display("FAIL stall_rd_op[%0d] got %0d/%0d want 8/%0d", i, rd, alu_op, ALU_ADD); end
            tick();
        end
        ready = 1'b1;
        #1;
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0d want 1", inst_ready); end
        tick();
        inst_valid = 1'b0;
        vectors++; if (valid !== 1'b1 || rd !== 5'd9) begin errors++; $display("FAIL stall_next got valid=%0d rd=%0d want 1/9", valid, rd); end
        tick();
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %0d want 0", valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad[0] = 32'h0000007F;
        bad[1] = enc_i({7'b0000001, 5'd1}, 5'd1, 3'b001, 5'd10);
        for (int i = 0; i < 2; i++) begin
            inst_valid = 1'b1; inst = bad[i];
            #1;
            vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL ill_ready[%0d] got %0d want 1", i, inst_ready); end
            tick();
            inst_valid = 1'b0;
            vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse[%0d] got %0d want 1", i, illegal); end
            vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL ill_valid[%0d] got %0d want 0", i, valid); end
            tick();
            vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_end[%0d] got %0d want 0", i, illegal); end
        end
        inst_valid = 1'b1; inst = enc_r(7'b0000000, 5'd10, 5'd10, 3'b000, 5'd11);
        #1;
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL ill_nobusy got %0d want 1", inst_ready); end
        tick();
        inst_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        inst_valid = 1'b1; inst = enc_i(12'd1, 5'd1, 3'b000, 5'd3);
        tick();
        inst = enc_r(7'b0000000, 5'd3, 5'd3, 3'b000, 5'd12);
        #1;
        vectors++; if (inst_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got %0d want 0", inst_ready); end
        vectors++; if (valid !== 1'b1 || a !== 32'd5 || b !== 32'd1) begin errors++; $display("FAIL mid_full got valid=%0d a=%h b=%h want 1/5/1", valid, a, b); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %0d want 0", valid); end
        vectors++; if (inst_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_free got %0d want 1", inst_ready); end
        vectors++; if (rd !== 5'd0) begin errors++; $display("FAIL mid_rst_rd got %0d want 0", rd); end
        #2;
        inst_valid = 1'b0;
        rst = 1'b0;
        ready = 1'b1;
        tick();
        inst_valid = 1'b1; inst = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd13);
        tick();
        inst_valid = 1'b0;
        vectors++; if (a !== 32'd0 || b !== 32'd0 || rd !== 5'd13) begin errors++; $display("FAIL mid_rf_cleared got a=%h b=%h rd=%0d want 0/0/13", a, b, rd); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_hazard();
        test_stall();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
